// File: rtl/bcd_display_scanner.sv
// -----------------------------------------------------------------------------
// bcd_display_scanner
//
// Time-multiplexed driver for a 5-digit common-anode seven-segment display.
//
// The five BCD digits are captured into a shadow register on a load strobe.
// One digit is shown per refresh slot of REFRESH_DIV clocks. Optional
// leading-zero blanking darkens high-order zero positions but keeps their
// timeslots. All pin-facing outputs are registered.
//
// Ports
//   clk          : system clock, rising edge
//   reset        : synchronous, active-high reset
//   load         : 1 = capture all five digit inputs at this edge
//   tenthousands : BCD digit, position 4 (leftmost)
//   thousands    : BCD digit, position 3
//   hundreds     : BCD digit, position 2
//   tens         : BCD digit, position 1
//   ones         : BCD digit, position 0 (rightmost)
//   blank_lz     : 1 = enable leading-zero blanking
//   an           : anode enables, bit k drives position k
//   seg          : segments {g,f,e,d,c,b,a}
//   frame_done   : one-cycle pulse when a full 5-digit scan completes
// -----------------------------------------------------------------------------
module bcd_display_scanner #(
  parameter int REFRESH_DIV      = 100000,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] tenthousands,
  input  logic [3:0] thousands,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       blank_lz,
  output logic [4:0] an,
  output logic [6:0] seg,
  output logic       frame_done
);

  localparam int            PW        = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [4:0]    AN_OFF    = {5{ANODE_ACTIVE_LOW}};
  localparam logic [6:0]    SEG_OFF   = {7{SEG_ACTIVE_LOW}};

  // Active-high segment pattern for one BCD digit; illegal codes show a dash.
  function automatic logic [6:0] f_seg7(input logic [3:0] i_digit);
    logic [6:0] v_seg;
    case (i_digit)
      4'd0:    v_seg = 7'h3F;
      4'd1:    v_seg = 7'h06;
      4'd2:    v_seg = 7'h5B;
      4'd3:    v_seg = 7'h4F;
      4'd4:    v_seg = 7'h66;
      4'd5:    v_seg = 7'h6D;
      4'd6:    v_seg = 7'h7D;
      4'd7:    v_seg = 7'h07;
      4'd8:    v_seg = 7'h7F;
      4'd9:    v_seg = 7'h6F;
      default: v_seg = 7'h40;
    endcase
    return v_seg;
  endfunction

  logic [3:0]    r_digit [0:4];
  logic [PW-1:0] r_prescale;
  logic [2:0]    r_index;
  logic          r_wrap;

  logic          w_tick;
  logic [4:0]    w_zero_from;
  logic [3:0]    w_cur_digit;
  logic [4:0]    w_an_onehot;
  logic          w_blank;
  logic [4:0]    w_an_next;
  logic [6:0]    w_seg_next;

  assign w_tick = (r_prescale == PRE_LAST);

  // Shadow digit register: captures all five digits on load, holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 5; k++) begin
        r_digit[k] <= 4'd0;
      end
    end else if (load) begin
      r_digit[4] <= tenthousands;
      r_digit[3] <= thousands;
      r_digit[2] <= hundreds;
      r_digit[1] <= tens;
      r_digit[0] <= ones;
    end else begin
      for (int k = 0; k < 5; k++) begin
        r_digit[k] <= r_digit[k];
      end
    end
  end

  // Refresh prescaler and digit index; r_wrap marks the first cycle of index 0
  // after a 4 -> 0 wrap so frame_done lines up with the other outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prescale <= '0;
      r_index    <= 3'd0;
      r_wrap     <= 1'b0;
    end else begin
      if (w_tick) begin
        r_prescale <= '0;
        r_index    <= (r_index == 3'd4) ? 3'd0 : (r_index + 3'd1);
      end else begin
        r_prescale <= r_prescale + PW'(1);
        r_index    <= r_index;
      end
      r_wrap <= w_tick && (r_index == 3'd4);
    end
  end

  // Digit select, leading-zero detection and next output values.
  // w_zero_from[k] is 1 when every shadow digit from position k to 4 is zero.
  always_comb begin
    w_zero_from    = 5'b00000;
    w_cur_digit    = 4'd0;
    w_an_onehot    = 5'b00000;
    w_blank        = 1'b0;
    w_an_next      = 5'b00000;
    w_seg_next     = 7'h00;

    w_zero_from[4] = (r_digit[4] == 4'd0);
    for (int k = 3; k >= 0; k--) begin
      w_zero_from[k] = w_zero_from[k+1] & (r_digit[k] == 4'd0);
    end

    case (r_index)
      3'd0:    begin w_cur_digit = r_digit[0]; w_an_onehot = 5'b00001; end
      3'd1:    begin w_cur_digit = r_digit[1]; w_an_onehot = 5'b00010; end
      3'd2:    begin w_cur_digit = r_digit[2]; w_an_onehot = 5'b00100; end
      3'd3:    begin w_cur_digit = r_digit[3]; w_an_onehot = 5'b01000; end
      3'd4:    begin w_cur_digit = r_digit[4]; w_an_onehot = 5'b10000; end
      default: begin w_cur_digit = 4'd0;       w_an_onehot = 5'b00000; end
    endcase

    // Position 0 is never blanked so an all-zero value still shows "0".
    if (blank_lz && (r_index != 3'd0) && (r_index <= 3'd4)) begin
      w_blank = w_zero_from[r_index];
    end else begin
      w_blank = 1'b0;
    end

    if (w_blank) begin
      w_an_next  = 5'b00000;
      w_seg_next = 7'h00;
    end else begin
      w_an_next  = w_an_onehot;
      w_seg_next = f_seg7(w_cur_digit);
    end
  end

  // Registered pin outputs with polarity applied; dark during reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      an         <= w_an_next ^ AN_OFF;
      seg        <= w_seg_next ^ SEG_OFF;
      frame_done <= r_wrap;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// -----------------------------------------------------------------------------
// Self-checking bench for bcd_display_scanner (REFRESH_DIV = 4, active-low
// anode and segment polarity). The reference model tracks the number of edges
// since the last reset edge plus a copy of the loaded digits. It derives the
// displayed position, blanking, segments and frame pulse arithmetically from
// those values.
// -----------------------------------------------------------------------------
module tb_bcd_display_scanner;

  localparam int DIV   = 4;
  localparam int FRAME = 5 * DIV;

  logic       clk = 1'b0;
  logic       reset, load, blank_lz;
  logic [3:0] tenthousands, thousands, hundreds, tens, ones;
  logic [4:0] an;
  logic [6:0] seg;
  logic       frame_done;

  int n_compared   = 0;
  int n_mismatched = 0;

  // reference model state
  int         m_k;          // edges since last reset edge
  logic [3:0] m_sh [0:4];   // shadow digit copy
  int         fd_pulses;    // frame_done pulses seen
  logic [6:0] seg_tab [0:15];

  bcd_display_scanner #(
    .REFRESH_DIV(DIV), .ANODE_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .load(load),
    .tenthousands(tenthousands), .thousands(thousands), .hundreds(hundreds),
    .tens(tens), .ones(ones), .blank_lz(blank_lz),
    .an(an), .seg(seg), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs at the falling edge, check outputs 1 time unit
  // after the rising edge against the model, then advance the model.
  task automatic cycle(input logic rst, input logic ld,
                       input logic [3:0] d4, input logic [3:0] d3, input logic [3:0] d2,
                       input logic [3:0] d1, input logic [3:0] d0, input logic blz);
    logic [4:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_fd;
    logic [4:0] one;
    int         pos;
    bit         blanked;
    @(negedge clk);
    reset = rst; load = ld; blank_lz = blz;
    tenthousands = d4; thousands = d3; hundreds = d2; tens = d1; ones = d0;
    @(posedge clk);
    #1;
    if (rst) begin
      exp_an = 5'h1F; exp_seg = 7'h7F; exp_fd = 1'b0;
      m_k = 0;
      for (int p = 0; p < 5; p++) m_sh[p] = 4'd0;
    end else begin
      pos     = (m_k / DIV) % 5;
      blanked = 1'b0;
      if (blz && pos > 0) begin
        blanked = 1'b1;
        for (int p = pos; p < 5; p++) if (m_sh[p] != 4'd0) blanked = 1'b0;
      end
      one = 5'b00001;
      if (blanked) begin
        exp_an = 5'h1F; exp_seg = 7'h7F;
      end else begin
        exp_an  = ~(one << pos);
        exp_seg = ~seg_tab[m_sh[pos]];
      end
      exp_fd = (m_k > 0) && ((m_k % FRAME) == 0);
      m_k++;
      if (ld) begin
        m_sh[4] = d4; m_sh[3] = d3; m_sh[2] = d2; m_sh[1] = d1; m_sh[0] = d0;
      end
    end
    check_eq("an", {27'd0, an}, {27'd0, exp_an});
    check_eq("seg", {25'd0, seg}, {25'd0, exp_seg});
    check_eq("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
    if (frame_done === 1'b1) fd_pulses++;
  endtask

  task automatic idle(input int n, input logic blz);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, blz);
  endtask

  initial begin
    seg_tab[0] = 7'h3F; seg_tab[1] = 7'h06; seg_tab[2] = 7'h5B; seg_tab[3] = 7'h4F;
    seg_tab[4] = 7'h66; seg_tab[5] = 7'h6D; seg_tab[6] = 7'h7D; seg_tab[7] = 7'h07;
    seg_tab[8] = 7'h7F; seg_tab[9] = 7'h6F;
    for (int v = 10; v < 16; v++) seg_tab[v] = 7'h40;
    m_k = 0;
    fd_pulses = 0;
    for (int p = 0; p < 5; p++) m_sh[p] = 4'd0;
    reset = 1'b1; load = 1'b0; blank_lz = 1'b0;
    tenthousands = 4'd0; thousands = 4'd0; hundreds = 4'd0; tens = 4'd0; ones = 4'd0;

    // reset for two cycles, then a couple of frames of plain scanning
    cycle(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    cycle(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    idle(2 * FRAME, 1'b0);

    // 25 with blanking on, then off
    cycle(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd2, 4'd5, 1'b1);
    idle(FRAME + 3, 1'b1);
    idle(FRAME + 1, 1'b0);

    // all zero with blanking, then an illegal hundreds digit
    cycle(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    idle(FRAME, 1'b1);
    cycle(1'b0, 1'b1, 4'd0, 4'd0, 4'hB, 4'd0, 4'd0, 1'b1);
    idle(FRAME, 1'b1);

    // ones 3 -> 8 while position 0 is on screen
    cycle(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd3, 1'b0);
    while (((m_k / DIV) % 5) != 0) cycle(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    cycle(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    cycle(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd8, 1'b0);
    idle(FRAME, 1'b0);

    // frame pulse spacing: exactly three pulses in the first 3 frames after reset
    cycle(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    fd_pulses = 0;
    idle(3 * FRAME + 1, 1'b0);
    check_eq("fd_count_3frames", fd_pulses, 32'd3);

    // reset mid-frame, then a full frame plus one
    idle(7, 1'b0);
    cycle(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    fd_pulses = 0;
    idle(FRAME, 1'b0);
    check_eq("fd_none_before_restart_frame", fd_pulses, 32'd0);
    idle(1, 1'b0);
    check_eq("fd_after_restart", fd_pulses, 32'd1);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic       r_rst, r_ld, r_blz;
      logic [3:0] d [0:4];
      r_rst = ($urandom_range(0, 199) == 0);
      r_ld  = ($urandom_range(0, 7) == 0);
      r_blz = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < 5; p++)
        d[p] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      cycle(r_rst, r_ld, d[4], d[3], d[2], d[1], d[0], r_blz);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
